// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffer pipeline stage with fully registered valid/ready/data outputs.
// Optional stall statistics counter is enabled by defining PIPE_STAGE_STALL_STAT_EN.
module pipe_stage_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData
`ifdef PIPE_STAGE_STALL_STAT_EN
    ,
    output logic [15:0]      StallCount
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             main_load;
    logic             main_from_skid;
    logic             skid_load;

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath load decode; Flush squashes without touching contents
    always_comb begin
        state_next     = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (Flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (InValid) begin
                        state_next = ONE;
                        main_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (InValid && OutReady) begin
                        main_load = 1'b1;
                    end else if (InValid) begin
                        state_next = TWO;
                        skid_load  = 1'b1;
                    end else if (OutReady) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    if (OutReady) begin
                        state_next     = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        OutValid = (state != EMPTY);
        InReady  = (state != TWO);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load) begin
                main_q <= main_from_skid ? skid_q : InData;
            end
            if (skid_load) begin
                skid_q <= InData;
            end
        end
    end

    assign OutData = main_q;

`ifdef PIPE_STAGE_STALL_STAT_EN
    localparam int unsigned STALL_W = 16;

    logic [STALL_W-1:0] stall_q;

    // Saturating count of cycles where an entry waits on downstream
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_q <= '0;
        end else if ((state != EMPTY) && !OutReady && (stall_q != {STALL_W{1'b1}})) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign StallCount = stall_q;
`endif

endmodule
